// File: rtl/rvcpu_axi_pkg.sv
// Shared AXI constants and FSM state types for the CPU-top AXI master arbiter.
package rvcpu_axi_pkg;

  localparam int          ID_W          = 4;
  localparam logic [1:0]  BURST_INCR    = 2'b01;
  localparam logic [3:0]  CACHE_DEFAULT = 4'b0010;
  localparam logic [ID_W-1:0] ID_ICACHE = 4'd0;
  localparam logic [ID_W-1:0] ID_DCACHE = 4'd1;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  typedef enum logic {
    W_IDLE,
    W_BUSY
  } wr_state_t;

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way round-robin picker; bit 0 is the I-cache, bit 1 the D-cache.
module axi_rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_q, last_d;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (update && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  // Reset to "D-cache granted last" so the first tie favours the I-cache.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one AXI4 master port between the I-cache (reads) and D-cache (reads + writes).
// Optional AXI_ARB_RAW_CHECK_EN: hold D-cache reads hitting the line of the pending write.
module axi_master_arbiter
  import rvcpu_axi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  // I-cache read
  input  logic                ic_ar_valid,
  output logic                ic_ar_ready,
  input  logic [ADDR_W-1:0]   ic_ar_addr,
  input  logic [7:0]          ic_ar_len,
  input  logic [2:0]          ic_ar_size,
  output logic                ic_r_valid,
  input  logic                ic_r_ready,
  output logic [DATA_W-1:0]   ic_r_data,
  output logic [1:0]          ic_r_resp,
  output logic                ic_r_last,
  // D-cache read
  input  logic                dc_ar_valid,
  output logic                dc_ar_ready,
  input  logic [ADDR_W-1:0]   dc_ar_addr,
  input  logic [7:0]          dc_ar_len,
  input  logic [2:0]          dc_ar_size,
  output logic                dc_r_valid,
  input  logic                dc_r_ready,
  output logic [DATA_W-1:0]   dc_r_data,
  output logic [1:0]          dc_r_resp,
  output logic                dc_r_last,
  // D-cache write
  input  logic                dc_aw_valid,
  output logic                dc_aw_ready,
  input  logic [ADDR_W-1:0]   dc_aw_addr,
  input  logic [7:0]          dc_aw_len,
  input  logic [2:0]          dc_aw_size,
  input  logic                dc_w_valid,
  output logic                dc_w_ready,
  input  logic [DATA_W-1:0]   dc_w_data,
  input  logic [DATA_W/8-1:0] dc_w_strb,
  input  logic                dc_w_last,
  output logic                dc_b_valid,
  input  logic                dc_b_ready,
  output logic [1:0]          dc_b_resp,
  // AXI4 master
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [ID_W-1:0]     m_arid,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arlock,
  output logic [3:0]          m_arcache,
  output logic [2:0]          m_arprot,
  output logic [3:0]          m_arqos,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [ID_W-1:0]     m_awid,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awlock,
  output logic [3:0]          m_awcache,
  output logic [2:0]          m_awprot,
  output logic [3:0]          m_awqos,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp
);

  rd_state_t         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]        ar_len_q, ar_len_d;
  logic [2:0]        ar_size_q, ar_size_d;
  logic              owner_q, owner_d;

  wr_state_t         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]        aw_len_q, aw_len_d;
  logic [2:0]        aw_size_q, aw_size_d;
  logic              aw_pend_q, aw_pend_d;
  logic              w_done_q, w_done_d;

  logic [1:0]        arb_req, arb_grant;
  logic              arb_update;
  logic              raw_hit;

`ifdef AXI_ARB_RAW_CHECK_EN
  localparam int LINE_OFF = $clog2(LINE_BYTES);
  assign raw_hit = (wr_state_q == W_BUSY) &&
                   (dc_ar_addr[ADDR_W-1:LINE_OFF] == aw_addr_q[ADDR_W-1:LINE_OFF]);
`else
  assign raw_hit = 1'b0;
`endif

  assign arb_req = {dc_ar_valid & ~raw_hit, ic_ar_valid};

  axi_rr_arb2 u_rr_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (arb_req),
    .update  (arb_update),
    .grant   (arb_grant)
  );

  // Read channel: grant in R_IDLE, replay the latched AR, then steer R beats to the owner.
  always_comb begin
    rd_state_d  = rd_state_q;
    ar_addr_d   = ar_addr_q;
    ar_len_d    = ar_len_q;
    ar_size_d   = ar_size_q;
    owner_d     = owner_q;
    arb_update  = 1'b0;
    ic_ar_ready = 1'b0;
    dc_ar_ready = 1'b0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    ic_r_valid  = 1'b0;
    dc_r_valid  = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        ic_ar_ready = arb_grant[0];
        dc_ar_ready = arb_grant[1];
        if (arb_grant != 2'b00) begin
          arb_update = 1'b1;
          owner_d    = arb_grant[1];
          ar_addr_d  = arb_grant[1] ? dc_ar_addr : ic_ar_addr;
          ar_len_d   = arb_grant[1] ? dc_ar_len  : ic_ar_len;
          ar_size_d  = arb_grant[1] ? dc_ar_size : ic_ar_size;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (owner_q) begin
          dc_r_valid = m_rvalid;
          m_rready   = dc_r_ready;
        end else begin
          ic_r_valid = m_rvalid;
          m_rready   = ic_r_ready;
        end
        if (m_rvalid && m_rready && m_rlast) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write channel: W may complete before AW is accepted; B ends the transaction.
  always_comb begin
    wr_state_d  = wr_state_q;
    aw_addr_d   = aw_addr_q;
    aw_len_d    = aw_len_q;
    aw_size_d   = aw_size_q;
    aw_pend_d   = aw_pend_q;
    w_done_d    = w_done_q;
    dc_aw_ready = 1'b0;
    dc_w_ready  = 1'b0;
    m_wvalid    = 1'b0;
    dc_b_valid  = 1'b0;
    m_bready    = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        dc_aw_ready = 1'b1;
        if (dc_aw_valid) begin
          aw_addr_d  = dc_aw_addr;
          aw_len_d   = dc_aw_len;
          aw_size_d  = dc_aw_size;
          aw_pend_d  = 1'b1;
          w_done_d   = 1'b0;
          wr_state_d = W_BUSY;
        end
      end
      W_BUSY: begin
        if (aw_pend_q && m_awready) begin
          aw_pend_d = 1'b0;
        end
        if (!w_done_q) begin
          m_wvalid   = dc_w_valid;
          dc_w_ready = m_wready;
          if (dc_w_valid && m_wready && dc_w_last) begin
            w_done_d = 1'b1;
          end
        end
        dc_b_valid = m_bvalid;
        m_bready   = dc_b_ready;
        if (m_bvalid && dc_b_ready) begin
          w_done_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q <= R_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      owner_q    <= 1'b0;
      wr_state_q <= W_IDLE;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_pend_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      owner_q    <= owner_d;
      wr_state_q <= wr_state_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_pend_q  <= aw_pend_d;
      w_done_q   <= w_done_d;
    end
  end

  assign m_araddr  = ar_addr_q;
  assign m_arid    = owner_q ? ID_DCACHE : ID_ICACHE;
  assign m_arlen   = ar_len_q;
  assign m_arsize  = ar_size_q;
  assign m_arburst = BURST_INCR;
  assign m_arlock  = 1'b0;
  assign m_arcache = CACHE_DEFAULT;
  assign m_arprot  = 3'b000;
  assign m_arqos   = 4'b0000;

  assign ic_r_data = m_rdata;
  assign ic_r_resp = m_rresp;
  assign ic_r_last = m_rlast;
  assign dc_r_data = m_rdata;
  assign dc_r_resp = m_rresp;
  assign dc_r_last = m_rlast;

  assign m_awvalid = aw_pend_q;
  assign m_awaddr  = aw_addr_q;
  assign m_awid    = ID_DCACHE;
  assign m_awlen   = aw_len_q;
  assign m_awsize  = aw_size_q;
  assign m_awburst = BURST_INCR;
  assign m_awlock  = 1'b0;
  assign m_awcache = CACHE_DEFAULT;
  assign m_awprot  = 3'b000;
  assign m_awqos   = 4'b0000;

  assign m_wdata   = dc_w_data;
  assign m_wstrb   = dc_w_strb;
  assign m_wlast   = dc_w_last;
  assign dc_b_resp = m_bresp;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed self-checking bench for axi_master_arbiter; the master-side slave is driven by hand.
module tb_axi_master_arbiter;

  localparam logic [31:0] IC_A  = 32'h1000_0000;
  localparam logic [31:0] DC_A  = 32'h2000_0100;
  localparam logic [31:0] WR_A  = 32'h8000_0040;
  localparam logic [31:0] RAW_A = 32'h8000_0048;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ic_ar_valid, ic_ar_ready, ic_r_valid, ic_r_ready, ic_r_last;
  logic [31:0] ic_ar_addr;
  logic [7:0]  ic_ar_len;
  logic [2:0]  ic_ar_size;
  logic [63:0] ic_r_data;
  logic [1:0]  ic_r_resp;
  logic        dc_ar_valid, dc_ar_ready, dc_r_valid, dc_r_ready, dc_r_last;
  logic [31:0] dc_ar_addr;
  logic [7:0]  dc_ar_len;
  logic [2:0]  dc_ar_size;
  logic [63:0] dc_r_data;
  logic [1:0]  dc_r_resp;
  logic        dc_aw_valid, dc_aw_ready, dc_w_valid, dc_w_ready, dc_w_last;
  logic        dc_b_valid, dc_b_ready;
  logic [31:0] dc_aw_addr;
  logic [7:0]  dc_aw_len;
  logic [2:0]  dc_aw_size;
  logic [63:0] dc_w_data;
  logic [7:0]  dc_w_strb;
  logic [1:0]  dc_b_resp;
  logic        m_arvalid, m_arready, m_arlock;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid, m_arcache, m_arqos;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize, m_arprot;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready, m_rlast;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_awvalid, m_awready, m_awlock;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awid, m_awcache, m_awqos;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize, m_awprot;
  logic [1:0]  m_awburst;
  logic        m_wvalid, m_wready, m_wlast;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;

  int checks = 0;
  int errors = 0;

  axi_master_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .ic_ar_valid(ic_ar_valid), .ic_ar_ready(ic_ar_ready), .ic_ar_addr(ic_ar_addr),
    .ic_ar_len(ic_ar_len), .ic_ar_size(ic_ar_size),
    .ic_r_valid(ic_r_valid), .ic_r_ready(ic_r_ready), .ic_r_data(ic_r_data),
    .ic_r_resp(ic_r_resp), .ic_r_last(ic_r_last),
    .dc_ar_valid(dc_ar_valid), .dc_ar_ready(dc_ar_ready), .dc_ar_addr(dc_ar_addr),
    .dc_ar_len(dc_ar_len), .dc_ar_size(dc_ar_size),
    .dc_r_valid(dc_r_valid), .dc_r_ready(dc_r_ready), .dc_r_data(dc_r_data),
    .dc_r_resp(dc_r_resp), .dc_r_last(dc_r_last),
    .dc_aw_valid(dc_aw_valid), .dc_aw_ready(dc_aw_ready), .dc_aw_addr(dc_aw_addr),
    .dc_aw_len(dc_aw_len), .dc_aw_size(dc_aw_size),
    .dc_w_valid(dc_w_valid), .dc_w_ready(dc_w_ready), .dc_w_data(dc_w_data),
    .dc_w_strb(dc_w_strb), .dc_w_last(dc_w_last),
    .dc_b_valid(dc_b_valid), .dc_b_ready(dc_b_ready), .dc_b_resp(dc_b_resp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock),
    .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arqos(m_arqos),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock),
    .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Called at a negedge with the read FSM in R_ADDR; plays the slave for one burst.
  task automatic serveRead(input logic owner, input logic [31:0] addr, input int beats);
    #1;
    checkOutput("m_arvalid", m_arvalid, 1);
    checkOutput("m_arid", m_arid, {3'b000, owner});
    checkOutput("m_araddr", m_araddr, addr);
    checkOutput("m_arlen", m_arlen, beats - 1);
    m_arready = 1'b1;
    nextCycle();
    m_arready = 1'b0;
    #1 checkOutput("m_arvalid_drop", m_arvalid, 0);
    for (int i = 0; i < beats; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = {32'hD0D0_0000, i};
      m_rresp  = 2'b00;
      m_rlast  = (i == beats - 1);
      #1;
      checkOutput("owner_r_valid", owner ? dc_r_valid : ic_r_valid, 1);
      checkOutput("other_r_valid", owner ? ic_r_valid : dc_r_valid, 0);
      checkOutput("owner_r_data", owner ? dc_r_data : ic_r_data, {32'hD0D0_0000, i});
      checkOutput("m_rready", m_rready, 1);
      nextCycle();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic applyStimulusAw(input logic [31:0] addr, input logic [7:0] len);
    dc_aw_valid = 1'b1;
    dc_aw_addr  = addr;
    dc_aw_len   = len;
    #1 checkOutput("dc_aw_ready_idle", dc_aw_ready, 1);
    nextCycle();
    dc_aw_valid = 1'b0;
    #1;
    checkOutput("m_awvalid", m_awvalid, 1);
    checkOutput("m_awaddr", m_awaddr, addr);
    checkOutput("m_awid", m_awid, 1);
    checkOutput("m_awlen", m_awlen, len);
  endtask

  // Accepts the pending AW, then returns a B response and confirms the FSM is idle again.
  task automatic finishWrite(input logic [1:0] resp);
    m_awready = 1'b1;
    nextCycle();
    m_awready = 1'b0;
    #1 checkOutput("m_awvalid_clr", m_awvalid, 0);
    m_bvalid   = 1'b1;
    m_bresp    = resp;
    dc_b_ready = 1'b1;
    #1;
    checkOutput("dc_b_valid", dc_b_valid, 1);
    checkOutput("dc_b_resp", dc_b_resp, resp);
    checkOutput("m_bready", m_bready, 1);
    nextCycle();
    m_bvalid   = 1'b0;
    dc_b_ready = 1'b0;
    #1;
    checkOutput("dc_aw_ready_back", dc_aw_ready, 1);
    checkOutput("dc_w_ready_idle", dc_w_ready, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    ic_ar_valid = 0; ic_ar_addr = IC_A; ic_ar_len = 0; ic_ar_size = 3; ic_r_ready = 0;
    dc_ar_valid = 0; dc_ar_addr = DC_A; dc_ar_len = 0; dc_ar_size = 3; dc_r_ready = 0;
    dc_aw_valid = 0; dc_aw_addr = 0; dc_aw_len = 0; dc_aw_size = 3;
    dc_w_valid = 0; dc_w_data = 0; dc_w_strb = 8'hFF; dc_w_last = 0; dc_b_ready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    nextCycle();

    // Idle after reset
    #1;
    checkOutput("rst_m_arvalid", m_arvalid, 0);
    checkOutput("rst_m_awvalid", m_awvalid, 0);
    checkOutput("rst_m_wvalid", m_wvalid, 0);
    checkOutput("rst_m_rready", m_rready, 0);
    checkOutput("rst_m_bready", m_bready, 0);
    checkOutput("rst_ic_ar_ready", ic_ar_ready, 0);
    checkOutput("rst_dc_ar_ready", dc_ar_ready, 0);
    checkOutput("rst_dc_aw_ready", dc_aw_ready, 1);
    checkOutput("rst_dc_w_ready", dc_w_ready, 0);
    checkOutput("rst_dc_b_valid", dc_b_valid, 0);
    nextCycle();

    // Simultaneous requests, 8-beat bursts: I first, then D
    ic_ar_valid = 1; ic_ar_len = 7; dc_ar_valid = 1; dc_ar_len = 7;
    ic_r_ready = 1; dc_r_ready = 1;
    #1;
    checkOutput("tie_ic_ar_ready", ic_ar_ready, 1);
    checkOutput("tie_dc_ar_ready", dc_ar_ready, 0);
    nextCycle();
    ic_ar_valid = 0;
    #1;
    checkOutput("raddr_dc_ar_ready", dc_ar_ready, 0);
    checkOutput("m_arburst", m_arburst, 2'b01);
    checkOutput("m_arcache", m_arcache, 4'b0010);
    serveRead(1'b0, IC_A, 8);
    #1 checkOutput("dc_wait_ar_ready", dc_ar_ready, 1);
    nextCycle();
    dc_ar_valid = 0;
    serveRead(1'b1, DC_A, 8);

    // Both keep requesting: grants alternate I, D, I
    ic_ar_valid = 1; ic_ar_len = 0; dc_ar_valid = 1; dc_ar_len = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("alt_ic_ar_ready", ic_ar_ready, (k % 2 == 0));
      checkOutput("alt_dc_ar_ready", dc_ar_ready, (k % 2 == 1));
      nextCycle();
      if (k == 2) begin
        ic_ar_valid = 0;
        dc_ar_valid = 0;
      end
      serveRead(k % 2 == 1, (k % 2 == 1) ? DC_A : IC_A, 1);
    end

    // 8-beat write with all W beats before the AW handshake
    applyStimulusAw(32'h4000_0000, 8'd7);
    m_wready = 1;
    for (int i = 0; i < 8; i++) begin
      dc_w_valid = 1;
      dc_w_data  = {32'hBEEF_0000, i};
      dc_w_last  = (i == 7);
      #1;
      checkOutput("w_m_wvalid", m_wvalid, 1);
      checkOutput("w_m_wdata", m_wdata, {32'hBEEF_0000, i});
      checkOutput("w_dc_w_ready", dc_w_ready, 1);
      checkOutput("w_aw_still_pend", m_awvalid, 1);
      nextCycle();
    end
    dc_w_last = 0;
    #1;
    checkOutput("w_done_m_wvalid", m_wvalid, 0);
    checkOutput("w_done_dc_w_ready", dc_w_ready, 0);
    dc_w_valid = 0;
    finishWrite(2'b10);

    // Read to the line of a pending write
    applyStimulusAw(WR_A, 8'd0);
    dc_ar_valid = 1; dc_ar_addr = RAW_A;
`ifdef AXI_ARB_RAW_CHECK_EN
    #1 checkOutput("raw_stall0", dc_ar_ready, 0);
    nextCycle();
    #1 checkOutput("raw_stall1", dc_ar_ready, 0);
    ic_ar_valid = 1;
    #1 checkOutput("raw_ic_wins", ic_ar_ready, 1);
    nextCycle();
    ic_ar_valid = 0;
    serveRead(1'b0, IC_A, 1);
    #1 checkOutput("raw_stall2", dc_ar_ready, 0);
    dc_w_valid = 1; dc_w_last = 1;
    nextCycle();
    dc_w_valid = 0; dc_w_last = 0;
    finishWrite(2'b00);
    checkOutput("raw_release", dc_ar_ready, 1);
    nextCycle();
    dc_ar_valid = 0;
    serveRead(1'b1, RAW_A, 1);
`else
    #1 checkOutput("noraw_grant", dc_ar_ready, 1);
    nextCycle();
    dc_ar_valid = 0;
    serveRead(1'b1, RAW_A, 1);
    dc_w_valid = 1; dc_w_last = 1;
    #1 checkOutput("noraw_w_ready", dc_w_ready, 1);
    nextCycle();
    dc_w_valid = 0; dc_w_last = 0;
    finishWrite(2'b00);
`endif

    // Reset during beat 3 of an I-cache burst
    ic_ar_valid = 1; ic_ar_len = 7;
    nextCycle();
    ic_ar_valid = 0;
    m_arready = 1;
    nextCycle();
    m_arready = 0;
    for (int i = 0; i < 3; i++) begin
      m_rvalid = 1; m_rdata = i; m_rlast = 0;
      nextCycle();
    end
    m_rvalid = 1; m_rdata = 3;
    reset_n = 0;
    #1;
    checkOutput("rst_mid_m_rready", m_rready, 0);
    checkOutput("rst_mid_ic_r_valid", ic_r_valid, 0);
    m_rvalid = 0;
    @(negedge clock);
    reset_n = 1;
    ic_ar_valid = 1; ic_ar_len = 0; dc_ar_valid = 1; dc_ar_len = 0; dc_ar_addr = DC_A;
    #1;
    checkOutput("post_rst_ic_ar_ready", ic_ar_ready, 1);
    checkOutput("post_rst_dc_ar_ready", dc_ar_ready, 0);
    nextCycle();
    ic_ar_valid = 0; dc_ar_valid = 0;
    serveRead(1'b0, IC_A, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
